// File: rtl/write_burst_ctrl.sv
// write_burst_ctrl
//   Turns a single-cycle write request into a six-beat write burst for a
//   downstream controller that is always ready (no back-pressure). On
//   acceptance the 768-bit payload and the start address are latched. Each
//   beat then presents one 128-bit slice of the payload together with an
//   address that advances by ADDR_STEP per beat, wrapping modulo 2^31.
//
//   Configuration macro: WRITE_BURST_MSB_FIRST_EN
//     undefined (default) : beat n carries data[128n+127:128n]   (LSB-first)
//     defined             : beat n carries data[767-128n:640-128n] (MSB-first)
//     Addresses ascend from address_in in both builds.
//
//   Ports
//     clk            in   rising-edge clock
//     reset          in   synchronous active-high reset, has priority over write
//     write          in   burst start request, ignored while busy
//     data[767:0]    in   burst payload, six 128-bit beats
//     address_in     in   burst start address (31 bits)
//     busy           out  high while a burst is in progress
//     write_enable   out  write-data valid strobe, one per beat
//     address_enable out  command/address valid strobe, one per beat
//     write_command  out  command code, constant CMD_WRITE
//     write_data     out  current beat data, 0 when idle
//     address_out    out  current beat address, 0 when idle
//   All outputs are registered.

module write_burst_ctrl #(
  parameter int unsigned ADDR_STEP = 8,
  parameter logic [2:0]  CMD_WRITE = 3'b000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         write,
  input  logic [767:0] data,
  input  logic [30:0]  address_in,
  output logic         busy,
  output logic         write_enable,
  output logic         address_enable,
  output logic [2:0]   write_command,
  output logic [127:0] write_data,
  output logic [30:0]  address_out
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  localparam logic [2:0]  LAST_BEAT = 3'd5;
  localparam logic [30:0] STEP      = 31'(ADDR_STEP);

  // State, beat counter and burst latches
  state_t         r_state;
  logic [2:0]     r_cnt;      // index of the beat currently on the outputs
  logic [767:0]   r_data;
  logic [30:0]    r_addr;

  // Registered outputs
  logic           r_busy;
  logic           r_write_enable;
  logic           r_address_enable;
  logic [2:0]     r_write_command;
  logic [127:0]   r_write_data;
  logic [30:0]    r_address_out;

  // Next-state / output-next signals
  state_t         w_next_state;
  logic [2:0]     w_next_cnt;
  logic           w_load;
  logic           w_strobe;
  logic [2:0]     w_slice;
  logic [767:0]   w_src_data;
  logic [30:0]    w_src_addr;
  logic [127:0]   w_beat_data;
  logic [30:0]    w_beat_addr;
  logic [127:0]   w_write_data_nxt;
  logic [30:0]    w_address_out_nxt;

  // State register: FSM state, beat counter and payload/address latches
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
      r_data  <= 768'd0;
      r_addr  <= 31'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (w_load) begin
        r_data <= data;
        r_addr <= address_in;
      end else begin
        r_data <= r_data;
        r_addr <= r_addr;
      end
    end
  end

  // Next-state logic: accept in IDLE, step through beats 0..5 in BURST
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_load       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_next_cnt = 3'd0;
        if (write) begin
          w_next_state = ST_BURST;
          w_load       = 1'b1;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_BURST: begin
        // write is deliberately not looked at here: requests while busy are dropped
        if (r_cnt == LAST_BEAT) begin
          w_next_state = ST_IDLE;
          w_next_cnt   = 3'd0;
        end else begin
          w_next_state = ST_BURST;
          w_next_cnt   = r_cnt + 3'd1;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_cnt   = 3'd0;
      end
    endcase
  end

  // Output logic: values the output registers take at the coming edge
  always_comb begin
    w_strobe          = 1'b0;
    w_src_data        = r_data;
    w_src_addr        = r_addr;
    w_slice           = 3'd0;
    w_beat_data       = 128'd0;
    w_beat_addr       = 31'd0;
    w_write_data_nxt  = 128'd0;
    w_address_out_nxt = 31'd0;

    if (w_next_state == ST_BURST) begin
      w_strobe = 1'b1;
    end else begin
      w_strobe = 1'b0;
    end

    // Beat 0 is registered in the same edge that accepts the request, so it
    // has to come straight from the inputs rather than from the latches.
    if (w_load) begin
      w_src_data = data;
      w_src_addr = address_in;
    end else begin
      w_src_data = r_data;
      w_src_addr = r_addr;
    end

`ifdef WRITE_BURST_MSB_FIRST_EN
    w_slice = LAST_BEAT - w_next_cnt;
`else
    w_slice = w_next_cnt;
`endif

    w_beat_data = w_src_data[{w_slice, 7'd0} +: 128];
    // 31-bit arithmetic: wraps silently past 31'h7FFFFFFF
    w_beat_addr = w_src_addr + (31'(w_next_cnt) * STEP);

    if (w_strobe) begin
      w_write_data_nxt  = w_beat_data;
      w_address_out_nxt = w_beat_addr;
    end else begin
      w_write_data_nxt  = 128'd0;
      w_address_out_nxt = 31'd0;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy           <= 1'b0;
      r_write_enable   <= 1'b0;
      r_address_enable <= 1'b0;
      r_write_command  <= CMD_WRITE;
      r_write_data     <= 128'd0;
      r_address_out    <= 31'd0;
    end else begin
      r_busy           <= w_strobe;
      r_write_enable   <= w_strobe;
      r_address_enable <= w_strobe;
      r_write_command  <= CMD_WRITE;
      r_write_data     <= w_write_data_nxt;
      r_address_out    <= w_address_out_nxt;
    end
  end

  assign busy           = r_busy;
  assign write_enable   = r_write_enable;
  assign address_enable = r_address_enable;
  assign write_command  = r_write_command;
  assign write_data     = r_write_data;
  assign address_out    = r_address_out;

endmodule

// File: tb/tb_write_burst_ctrl.sv
// Self-checking bench for write_burst_ctrl. A behavioural model turns each
// accepted request into a list of six expected beats and plays them out one
// per clock; every cycle all outputs are compared against it.
module tb_write_burst_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         write;
  logic [767:0] data;
  logic [30:0]  address_in;
  logic         busy;
  logic         write_enable;
  logic         address_enable;
  logic [2:0]   write_command;
  logic [127:0] write_data;
  logic [30:0]  address_out;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [127:0] d;
    logic [30:0]  a;
  } beat_t;

  beat_t q[$];
  beat_t cur;
  bit    cur_v = 1'b0;

  always #5 clk = ~clk;

  write_burst_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .write          (write),
    .data           (data),
    .address_in     (address_in),
    .busy           (busy),
    .write_enable   (write_enable),
    .address_enable (address_enable),
    .write_command  (write_command),
    .write_data     (write_data),
    .address_out    (address_out)
  );

  function automatic beat_t mk_beat(input logic [767:0] d, input logic [30:0] a, input int n);
    beat_t b;
    int    s;
`ifdef WRITE_BURST_MSB_FIRST_EN
    s = 5 - n;
`else
    s = n;
`endif
    b.d = d[s*128 +: 128];
    b.a = a + 31'(n * 8);
    return b;
  endfunction

  function automatic logic [767:0] rand768();
    logic [767:0] r;
    for (int i = 0; i < 24; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: advance the model with the inputs seen at this edge, then compare.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      q.delete();
      cur_v = 1'b0;
    end else if (cur_v) begin
      if (q.size() > 0) cur = q.pop_front();
      else cur_v = 1'b0;
    end else if (write) begin
      for (int n = 0; n < 6; n++) q.push_back(mk_beat(data, address_in, n));
      cur   = q.pop_front();
      cur_v = 1'b1;
    end
    #1;
    check("busy",           {127'd0, busy},           {127'd0, cur_v});
    check("write_enable",   {127'd0, write_enable},   {127'd0, cur_v});
    check("address_enable", {127'd0, address_enable}, {127'd0, cur_v});
    check("write_command",  {125'd0, write_command},  128'd0);
    check("write_data",     write_data,               cur_v ? cur.d : 128'd0);
    check("address_out",    {97'd0, address_out},     cur_v ? {97'd0, cur.a} : 128'd0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(input logic [767:0] d, input logic [30:0] a);
    data = d; address_in = a; write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  initial begin
    reset = 1'b1; write = 1'b0; data = 768'd0; address_in = 31'd0;
    ticks(2);
    reset = 1'b0;
    ticks(2);

    // data=1, addr=1: beats 1,0,0,0,0,0 at 1,9,...,41
    pulse(768'd1, 31'd1);
    ticks(7);

    // six distinct beats from address 0
    pulse({128'h6, 128'h5, 128'h4, 128'h3, 128'h2, 128'h1}, 31'd0);
    ticks(7);

    // address wrap
    pulse(rand768(), 31'h7FFFFFF8);
    ticks(7);

    // write held 3 cycles with changing inputs, then re-pulse on the idle cycle
    data = rand768(); address_in = 31'($urandom); write = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      data = rand768(); address_in = 31'($urandom);
      tick();
    end
    write = 1'b0;
    ticks(4);
    pulse(rand768(), 31'($urandom));
    ticks(7);

    // inputs change and write pulses mid-burst
    pulse(rand768(), 31'($urandom));
    for (int i = 0; i < 5; i++) begin
      data = rand768(); address_in = 31'($urandom); write = i[0];
      tick();
    end
    write = 1'b0;
    ticks(3);

    // reset during beat 3 aborts the burst
    pulse(rand768(), 31'($urandom));
    ticks(3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ticks(7);

    // reset has priority over write
    reset = 1'b1; write = 1'b1; data = rand768(); address_in = 31'($urandom);
    tick();
    reset = 1'b0; write = 1'b0;
    ticks(2);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      write      = ($urandom_range(0, 3) == 0);
      reset      = ($urandom_range(0, 40) == 0);
      data       = rand768();
      address_in = ($urandom_range(0, 4) == 0) ? 31'h7FFFFFF0 + 31'($urandom_range(0, 15))
                                               : 31'($urandom);
      tick();
    end
    write = 1'b0; reset = 1'b0;
    ticks(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
